// File: rtl/bank64k_arbiter.sv
// Round-robin write/read arbiter sharing one bank64k between requesters I, D and C.
// Optional read-after-write collision stall: define BANK64K_ARB_COLL_STALL_EN.
module bank64k_arbiter #(
    parameter int a     = 10,
    parameter int RDLAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2:0]     wreq,
    input  logic [3*a-1:0] waddr,
    output logic [2:0]     wgnt,
    input  logic [2:0]     rreq,
    input  logic [3*a-1:0] raddr,
    output logic [2:0]     rgnt,
    output logic [2:0]     rvalid,
    output logic           bank_wr_en,
    output logic [a-1:0]   bank_wr_addr,
    output logic [1:0]     bank_wr_muxcode,
    output logic           bank_rd_en,
    output logic [a-1:0]   bank_rd_addr
);

    logic [1:0]             wptr, rptr;
    logic [2:0]             wcand, rcand;
    logic [1:0]             widx, ridx;
    logic [a-1:0]           wsel_addr, rsel_addr;
    logic                   coll;
    logic [2:0]             rd_tag;
    logic [RDLAT:0][2:0]    tag_pipe;

    // Search starts at ptr and wraps modulo 3; first requesting slot wins.
    function automatic logic [2:0] rr_grant(input logic [2:0] req, input logic [1:0] ptr);
        logic [2:0] g;
        logic [1:0] k;
        g = 3'b000;
        k = ptr;
        for (int i = 0; i < 3; i++) begin
            if (g == 3'b000 && req[k])
                g[k] = 1'b1;
            k = (k == 2'd2) ? 2'd0 : k + 2'd1;
        end
        return g;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [2:0] g);
        return g[2] ? 2'd2 : (g[1] ? 2'd1 : 2'd0);
    endfunction

    function automatic logic [1:0] ptr_after(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    always_comb begin
        wcand     = rr_grant(wreq, wptr);
        rcand     = rr_grant(rreq, rptr);
        widx      = onehot_idx(wcand);
        ridx      = onehot_idx(rcand);
        wsel_addr = waddr[widx*a +: a];
        rsel_addr = raddr[ridx*a +: a];
        coll      = 1'b0;
`ifdef BANK64K_ARB_COLL_STALL_EN
        // Hold the read back one cycle so it observes the data being written.
        coll      = (|wcand) && (|rcand) && (rsel_addr == wsel_addr);
`endif
        wgnt      = rst ? 3'b000 : wcand;
        rgnt      = (rst || coll) ? 3'b000 : rcand;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr            <= 2'd0;
            bank_wr_en      <= 1'b0;
            bank_wr_addr    <= '0;
            bank_wr_muxcode <= 2'd0;
        end else if (|wgnt) begin
            wptr            <= ptr_after(widx);
            bank_wr_en      <= 1'b1;
            bank_wr_addr    <= wsel_addr;
            bank_wr_muxcode <= widx;
        end else begin
            bank_wr_en      <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr         <= 2'd0;
            bank_rd_en   <= 1'b0;
            bank_rd_addr <= '0;
        end else if (|rgnt) begin
            rptr         <= ptr_after(ridx);
            bank_rd_en   <= 1'b1;
            bank_rd_addr <= rsel_addr;
        end else begin
            bank_rd_en   <= 1'b0;
        end
    end

    // Tag travels alongside the registered rd_en, then RDLAT+1 stages to rvalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_tag   <= 3'b000;
            tag_pipe <= '0;
        end else begin
            rd_tag   <= rgnt;
            tag_pipe <= {tag_pipe[RDLAT-1:0], rd_tag};
        end
    end

    assign rvalid = tag_pipe[RDLAT];

endmodule

// File: tb/tb_bank64k_arbiter.sv
// Directed self-checking bench for bank64k_arbiter (default parameters, RDLAT=1).
module tb_bank64k_arbiter;

    localparam int A = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [2:0]     wreq = 3'b000;
    logic [3*A-1:0] waddr = '0;
    logic [2:0]     wgnt;
    logic [2:0]     rreq = 3'b000;
    logic [3*A-1:0] raddr = '0;
    logic [2:0]     rgnt;
    logic [2:0]     rvalid;
    logic           bank_wr_en;
    logic [A-1:0]   bank_wr_addr;
    logic [1:0]     bank_wr_muxcode;
    logic           bank_rd_en;
    logic [A-1:0]   bank_rd_addr;

    int checks = 0;
    int errors = 0;

    bank64k_arbiter #(.a(A), .RDLAT(1)) dut (
        .clk(clk), .rst(rst),
        .wreq(wreq), .waddr(waddr), .wgnt(wgnt),
        .rreq(rreq), .raddr(raddr), .rgnt(rgnt), .rvalid(rvalid),
        .bank_wr_en(bank_wr_en), .bank_wr_addr(bank_wr_addr),
        .bank_wr_muxcode(bank_wr_muxcode),
        .bank_rd_en(bank_rd_en), .bank_rd_addr(bank_rd_addr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wreq = 3'b000;
        rreq = 3'b000;
        rst  = 1'b1;
        step();
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if ({bank_wr_en, bank_rd_en, bank_wr_addr, bank_rd_addr, bank_wr_muxcode} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_regs: got wr_en=%b rd_en=%b wa=%h ra=%h mux=%0d expected all 0",
                     bank_wr_en, bank_rd_en, bank_wr_addr, bank_rd_addr, bank_wr_muxcode);
        end
        checks++;
        if (rvalid !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_rvalid: got %b expected 000", rvalid);
        end
        // Start a burst, then hit reset between clock edges.
        rst   = 1'b0;
        wreq  = 3'b111;
        rreq  = 3'b111;
        waddr = {10'h0C3, 10'h0D2, 10'h0E1};
        raddr = {10'h1C3, 10'h1D2, 10'h1E1};
        step();
        step();
        step();
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({bank_wr_en, bank_rd_en, bank_wr_addr, bank_rd_addr, bank_wr_muxcode} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_async_regs: got wr_en=%b rd_en=%b wa=%h ra=%h mux=%0d expected all 0",
                     bank_wr_en, bank_rd_en, bank_wr_addr, bank_rd_addr, bank_wr_muxcode);
        end
        checks++;
        if ({wgnt, rgnt, rvalid} !== 9'b0) begin
            errors++;
            $display("[TB] FAIL reset_async_gnt: got wgnt=%b rgnt=%b rvalid=%b expected 0",
                     wgnt, rgnt, rvalid);
        end
        wreq = 3'b000;
        rreq = 3'b000;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (rvalid !== 3'b000) begin
                errors++;
                $display("[TB] FAIL reset_flush[%0d]: got rvalid=%b expected 000", i, rvalid);
            end
        end
        wreq = 3'b111;
        rreq = 3'b111;
        #1;
        checks++;
        if (wgnt !== 3'b001 || rgnt !== 3'b001) begin
            errors++;
            $display("[TB] FAIL reset_first_grant: got wgnt=%b rgnt=%b expected 001/001", wgnt, rgnt);
        end
        wreq = 3'b000;
        rreq = 3'b000;
        step();
    endtask

    task automatic test_write_rr();
        logic [A-1:0] exp_addr [3];
        exp_addr[0] = 10'h011;
        exp_addr[1] = 10'h022;
        exp_addr[2] = 10'h033;
        do_reset();
        wreq  = 3'b111;
        waddr = {10'h033, 10'h022, 10'h011};
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (wgnt !== (3'b001 << (i % 3))) begin
                errors++;
                $display("[TB] FAIL write_rr_gnt[%0d]: got %b expected %b", i, wgnt, 3'b001 << (i % 3));
            end
            step();
            checks++;
            if (bank_wr_en !== 1'b1 || bank_wr_muxcode !== 2'(i % 3) || bank_wr_addr !== exp_addr[i % 3]) begin
                errors++;
                $display("[TB] FAIL write_rr_issue[%0d]: got en=%b mux=%0d addr=%h expected en=1 mux=%0d addr=%h",
                         i, bank_wr_en, bank_wr_muxcode, bank_wr_addr, i % 3, exp_addr[i % 3]);
            end
        end
        wreq = 3'b000;
        step();
        checks++;
        if (bank_wr_en !== 1'b0 || bank_wr_muxcode !== 2'd2 || bank_wr_addr !== 10'h033) begin
            errors++;
            $display("[TB] FAIL write_idle_hold: got en=%b mux=%0d addr=%h expected en=0 mux=2 addr=033",
                     bank_wr_en, bank_wr_muxcode, bank_wr_addr);
        end
    endtask

    task automatic test_read_rr();
        logic [2:0] exp_g [8];
        logic [2:0] exp_v;
        exp_g = '{3'b001, 3'b100, 3'b001, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
        do_reset();
        raddr = {10'h00C, 10'h00B, 10'h00A};
        for (int c = 0; c < 8; c++) begin
            rreq = (c < 4) ? 3'b101 : 3'b000;
            #1;
            exp_v = (c >= 3) ? exp_g[c-3] : 3'b000;
            checks++;
            if (rgnt !== exp_g[c] || rvalid !== exp_v) begin
                errors++;
                $display("[TB] FAIL read_rr[%0d]: got rgnt=%b rvalid=%b expected rgnt=%b rvalid=%b",
                         c, rgnt, rvalid, exp_g[c], exp_v);
            end
            step();
        end
    endtask

    task automatic test_single();
        logic [2:0] exp_v;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            rreq = (c < 8) ? 3'b010 : 3'b000;
            raddr[A +: A] = A'(c);
            #1;
            exp_v = (c >= 3 && c < 11) ? 3'b010 : 3'b000;
            checks++;
            if (rgnt !== ((c < 8) ? 3'b010 : 3'b000) || rvalid !== exp_v) begin
                errors++;
                $display("[TB] FAIL single[%0d]: got rgnt=%b rvalid=%b expected rgnt=%b rvalid=%b",
                         c, rgnt, rvalid, (c < 8) ? 3'b010 : 3'b000, exp_v);
            end
            step();
            if (c < 8) begin
                checks++;
                if (bank_rd_en !== 1'b1 || bank_rd_addr !== A'(c)) begin
                    errors++;
                    $display("[TB] FAIL single_addr[%0d]: got en=%b addr=%h expected en=1 addr=%h",
                             c, bank_rd_en, bank_rd_addr, A'(c));
                end
            end
        end
    endtask

    task automatic test_parallel();
        do_reset();
        wreq  = 3'b001;
        waddr = {10'h000, 10'h000, 10'h100};
        rreq  = 3'b010;
        raddr = {10'h000, 10'h0FF, 10'h000};
        #1;
        checks++;
        if (wgnt !== 3'b001 || rgnt !== 3'b010) begin
            errors++;
            $display("[TB] FAIL parallel_gnt: got wgnt=%b rgnt=%b expected 001/010", wgnt, rgnt);
        end
        step();
        checks++;
        if (bank_wr_en !== 1'b1 || bank_wr_addr !== 10'h100 || bank_rd_en !== 1'b1 || bank_rd_addr !== 10'h0FF) begin
            errors++;
            $display("[TB] FAIL parallel_issue: got wr=%b/%h rd=%b/%h expected 1/100 1/0ff",
                     bank_wr_en, bank_wr_addr, bank_rd_en, bank_rd_addr);
        end
        // Same requester holds both grants.
        wreq  = 3'b100;
        waddr = {10'h2AA, 10'h000, 10'h000};
        rreq  = 3'b100;
        raddr = {10'h2AB, 10'h000, 10'h000};
        #1;
        checks++;
        if (wgnt !== 3'b100 || rgnt !== 3'b100) begin
            errors++;
            $display("[TB] FAIL same_req_gnt: got wgnt=%b rgnt=%b expected 100/100", wgnt, rgnt);
        end
        step();
        checks++;
        if (bank_wr_muxcode !== 2'd2 || bank_wr_addr !== 10'h2AA || bank_rd_addr !== 10'h2AB) begin
            errors++;
            $display("[TB] FAIL same_req_issue: got mux=%0d wa=%h ra=%h expected 2 2aa 2ab",
                     bank_wr_muxcode, bank_wr_addr, bank_rd_addr);
        end
        wreq = 3'b000;
        rreq = 3'b000;
    endtask

    task automatic test_collision();
        do_reset();
        wreq  = 3'b010;
        waddr = {10'h000, 10'h155, 10'h000};
        rreq  = 3'b100;
        raddr = {10'h155, 10'h000, 10'h000};
        #1;
`ifdef BANK64K_ARB_COLL_STALL_EN
        checks++;
        if (wgnt !== 3'b010 || rgnt !== 3'b000) begin
            errors++;
            $display("[TB] FAIL coll_stall_gnt: got wgnt=%b rgnt=%b expected 010/000", wgnt, rgnt);
        end
        step();
        wreq = 3'b000;
        checks++;
        if (bank_wr_en !== 1'b1 || bank_wr_addr !== 10'h155 || bank_rd_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL coll_stall_issue: got wr=%b/%h rd_en=%b expected 1/155 0",
                     bank_wr_en, bank_wr_addr, bank_rd_en);
        end
        #1;
        checks++;
        if (rgnt !== 3'b100) begin
            errors++;
            $display("[TB] FAIL coll_retry_gnt: got rgnt=%b expected 100", rgnt);
        end
        step();
        rreq = 3'b000;
        checks++;
        if (bank_rd_en !== 1'b1 || bank_rd_addr !== 10'h155 || bank_wr_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL coll_retry_issue: got rd=%b/%h wr_en=%b expected 1/155 0",
                     bank_rd_en, bank_rd_addr, bank_wr_en);
        end
`else
        checks++;
        if (wgnt !== 3'b010 || rgnt !== 3'b100) begin
            errors++;
            $display("[TB] FAIL coll_both_gnt: got wgnt=%b rgnt=%b expected 010/100", wgnt, rgnt);
        end
        step();
        wreq = 3'b000;
        rreq = 3'b000;
        checks++;
        if (bank_wr_en !== 1'b1 || bank_rd_en !== 1'b1 || bank_wr_addr !== 10'h155 || bank_rd_addr !== 10'h155) begin
            errors++;
            $display("[TB] FAIL coll_both_issue: got wr=%b/%h rd=%b/%h expected 1/155 1/155",
                     bank_wr_en, bank_wr_addr, bank_rd_en, bank_rd_addr);
        end
`endif
        step();
    endtask

    initial begin
        test_reset();
        test_write_rr();
        test_read_rr();
        test_single();
        test_parallel();
        test_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
